// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: accepts a WIDTH-bit word on load & ready and
// shifts it out one bit per clock with valid, last and busy strobes.
module serial_tx #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CntW-1:0]  r_cnt;

  logic             w_shift;
  logic             w_last;
  logic             w_accept;
  logic             w_head;
  logic [WIDTH-1:0] w_shifted;

  assign w_shift  = (r_state == StShift);
  assign w_last   = w_shift && (r_cnt == LastCnt);
  assign w_accept = load && ready;

  // Output end is bit 0 for LSB-first, bit WIDTH-1 for MSB-first; fill with zeros.
  assign w_head    = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (load) begin
            r_shreg <= in;
            r_cnt   <= '0;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (w_last) begin
            r_cnt <= '0;
            if (load) begin
              r_shreg <= in;
            end else begin
              r_shreg <= w_shifted;
              r_state <= StIdle;
            end
          end else begin
            r_shreg <= w_shifted;
            r_cnt   <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign ready     = !w_shift || w_last;
  assign out       = w_shift && w_head;
  assign out_valid = w_shift;
  assign last      = w_last;
  assign busy      = w_shift;

  logic w_unused;
  assign w_unused = w_accept;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one LSB-first and one MSB-first instance share stimulus.
module tb_serial_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in = '0;
  logic        load = 1'b0;

  logic ready_l, out_l, valid_l, last_l, busy_l;
  logic ready_m, out_m, valid_m, last_m, busy_m;
  logic [4:0] obs_l, obs_m;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(16), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .in(in), .load(load), .ready(ready_l),
    .out(out_l), .out_valid(valid_l), .last(last_l), .busy(busy_l)
  );

  serial_tx #(.WIDTH(16), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .in(in), .load(load), .ready(ready_m),
    .out(out_m), .out_valid(valid_m), .last(last_m), .busy(busy_m)
  );

  // Packed as {ready, out, out_valid, last, busy}
  assign obs_l = {ready_l, out_l, valid_l, last_l, busy_l};
  assign obs_m = {ready_m, out_m, valid_m, last_m, busy_m};

  localparam logic [4:0] Idle = 5'b10000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    load  = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (obs_l !== Idle) begin
        n_err++;
        $display("FAIL reset_idle_lsb cycle %0d got %b exp %b", i, obs_l, Idle);
      end
      n_vec++;
      if (obs_m !== Idle) begin
        n_err++;
        $display("FAIL reset_idle_msb cycle %0d got %b exp %b", i, obs_m, Idle);
      end
      step();
    end
  endtask

  task automatic test_single(input logic msb, input logic [15:0] word);
    logic [4:0] exp;
    logic       bit_e;
    in   = word;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit_e = msb ? word[15 - i] : word[i];
      exp   = {(i == 15), bit_e, 1'b1, (i == 15), 1'b1};
      n_vec++;
      if ((msb ? obs_m : obs_l) !== exp) begin
        n_err++;
        $display("FAIL single_%s word %h bit %0d got %b exp %b", msb ? "msb" : "lsb", word, i,
                 msb ? obs_m : obs_l, exp);
      end
      step();
    end
    n_vec++;
    if ((msb ? obs_m : obs_l) !== Idle) begin
      n_err++;
      $display("FAIL single_after_idle got %b exp %b", msb ? obs_m : obs_l, Idle);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       edge_bit;
    in   = 16'hFFFF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 32; i++) begin
      edge_bit = (i == 15) || (i == 31);
      exp = {edge_bit, (i < 16), 1'b1, edge_bit, 1'b1};
      n_vec++;
      if (obs_l !== exp) begin
        n_err++;
        $display("FAIL b2b_lsb cycle %0d got %b exp %b", i, obs_l, exp);
      end
      n_vec++;
      if (obs_m !== exp) begin
        n_err++;
        $display("FAIL b2b_msb cycle %0d got %b exp %b", i, obs_m, exp);
      end
      if (i == 15) begin
        in   = 16'h0000;
        load = 1'b1;
      end
      step();
      load = 1'b0;
    end
    n_vec++;
    if (obs_l !== Idle) begin
      n_err++;
      $display("FAIL b2b_after_idle got %b exp %b", obs_l, Idle);
    end
  endtask

  task automatic test_load_ignored();
    logic [4:0] exp;
    in   = 16'h0001;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = {(i == 15), (i == 0), 1'b1, (i == 15), 1'b1};
      n_vec++;
      if (obs_l !== exp) begin
        n_err++;
        $display("FAIL ignore_lsb bit %0d got %b exp %b", i, obs_l, exp);
      end
      if (i == 4) begin
        in   = 16'hFFFF;
        load = 1'b1;
      end
      if (i == 5) load = 1'b0;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (obs_l !== Idle) begin
        n_err++;
        $display("FAIL ignore_no_second_word cycle %0d got %b exp %b", i, obs_l, Idle);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_word();
    in   = 16'h00FF;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++;
    if (obs_l !== Idle) begin
      n_err++;
      $display("FAIL midreset_lsb got %b exp %b", obs_l, Idle);
    end
    n_vec++;
    if (obs_m !== Idle) begin
      n_err++;
      $display("FAIL midreset_msb got %b exp %b", obs_m, Idle);
    end
    test_single(1'b0, 16'h8000);
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 16'hA5C3);
    test_single(1'b1, 16'hA5C3);
    test_back_to_back();
    test_load_ignored();
    test_reset_mid_word();
    test_single(1'b1, 16'h8000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
